// File: rtl/mc_defs.sv
// Shared memory-controller definitions:
// bus arbiter state encoding and the common burst length.
package mc_defs;

  localparam int BURST_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    TURN
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: rotate req by rr_ptr,
// take the lowest set bit, rotate the index back.
module rr_picker #(
  parameter int N_REQ = 4,
  localparam int W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     rr_ptr,
  output logic [W-1:0]     winner,
  output logic             any_req
);

  logic [N_REQ-1:0] rot;
  logic [W:0]       sum;

  always_comb begin
    rot = N_REQ'({req, req} >> rr_ptr);
    sum = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) sum = (W+1)'(i) + {1'b0, rr_ptr};
    end
    if (sum >= (W+1)'(N_REQ))
      winner = W'(sum - (W+1)'(N_REQ));
    else
      winner = sum[W-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/mc_bus_arbiter.sv
// Round-robin main-bus arbiter: one grant per transaction,
// revoke on unused grant, one-cycle turnaround.
module mc_bus_arbiter
  import mc_defs::*;
#(
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = mc_defs::BURST_LEN,
  parameter int TIMEOUT   = 8,
  localparam int W  = $clog2(N_REQ),
  localparam int MX = (BURST_LEN > TIMEOUT) ? BURST_LEN : TIMEOUT,
  localparam int CW = $clog2(MX) + 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [N_REQ-1:0] req,
  input  logic             addr_valid,
  output logic [N_REQ-1:0] gnt,
  output logic [W-1:0]     owner,
  output logic             bus_busy,
  output logic             timeout_err
);

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [W-1:0]     owner_n, rr_ptr, rr_n, ptr_nxt, winner;
  logic             busy_n, terr_n, any_req;
  logic [CW-1:0]    wait_cnt, wait_n, data_cnt, data_n;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    busy_n  = bus_busy;
    terr_n  = 1'b0;
    rr_n    = rr_ptr;
    wait_n  = wait_cnt;
    data_n  = data_cnt;
    if (owner == W'(N_REQ - 1))
      ptr_nxt = '0;
    else
      ptr_nxt = owner + 1'b1;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n = GRANT;
          gnt_n   = N_REQ'(1) << winner;
          owner_n = winner;
          busy_n  = 1'b1;
          wait_n  = '0;
        end
      end
      GRANT: begin
        // AddrValid wins over a same-cycle req drop or timeout
        if (addr_valid) begin
          state_n = XFER;
          data_n  = '0;
        end else if (!req[owner]) begin
          state_n = TURN;
          gnt_n   = '0;
          busy_n  = 1'b0;
          rr_n    = ptr_nxt;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          state_n = TURN;
          gnt_n   = '0;
          busy_n  = 1'b0;
          terr_n  = 1'b1;
          rr_n    = ptr_nxt;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      XFER: begin
        if (data_cnt == CW'(BURST_LEN - 1)) begin
          state_n = TURN;
          gnt_n   = '0;
          busy_n  = 1'b0;
          rr_n    = ptr_nxt;
        end else begin
          data_n = data_cnt + 1'b1;
        end
      end
      TURN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      data_cnt    <= '0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      owner       <= owner_n;
      bus_busy    <= busy_n;
      timeout_err <= terr_n;
      rr_ptr      <= rr_n;
      wait_cnt    <= wait_n;
      data_cnt    <= data_n;
    end
  end

endmodule

// File: tb/tb_mc_bus_arbiter.sv
// Scoreboard bench for mc_bus_arbiter: driver pushes expected
// grants, a negedge monitor measures and compares them.
module tb_mc_bus_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         addr_valid = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         bus_busy, timeout_err;

  typedef struct {
    int idx;
    int len;
    bit te;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rr = 0;
  int   last_owner = 0;
  bit   mon_en = 0;
  bit   done = 0;
  bit   gap_exact = 0;

  mc_bus_arbiter #(
    .N_REQ(N), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .req         (req),
    .addr_valid  (addr_valid),
    .gnt         (gnt),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: first requester at or after the pointer, wrapping
  function automatic int pick(input logic [N-1:0] p);
    for (int k = 0; k < N; k++)
      if (p[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++)
      if (g[i]) return i;
    return -1;
  endfunction

  // act: 0 complete after d wait cycles, 1 drop req after d, 2 timeout
  task automatic run_txn(input logic [N-1:0] pat, input int act,
                         input int d, input bit xdrop,
                         input bit spur, input bit chain);
    exp_t e;
    int   w;
    int   n;
    w = pick(pat);
    e.idx = w;
    e.te  = (act == 2);
    e.len = (act == 0) ? d + 1 + BL : (act == 1) ? d + 1 : TO;
    sb.push_back(e);
    gap_exact = chain;
    req = pat;
    n = 0;
    while (gnt == '0 && n < 6) begin tick(); n++; end
    if (gnt == '0) begin
      check(1'b0, "grant_wait", 0, 1);
      return;
    end
    if (act == 0) begin
      repeat (d) tick();
      addr_valid = 1'b1;
      if (xdrop) req[w] = 1'b0;
      tick();
      addr_valid = 1'b0;
    end else if (act == 1) begin
      repeat (d) tick();
      req[w] = 1'b0;
    end
    n = 0;
    while (gnt != '0 && n < 30) begin tick(); n++; end
    if (gnt != '0) check(1'b0, "release_wait", 1, 0);
    rr = (w + 1) % N;
    if (spur) begin
      addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
    end
  endtask

  task automatic reset_txn();
    exp_t e;
    int   n;
    e.idx = 2;
    e.len = 3;
    e.te  = 1'b0;
    sb.push_back(e);
    gap_exact = 1'b1;
    req = 4'b0100;
    n = 0;
    while (gnt == '0 && n < 6) begin tick(); n++; end
    addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    tick();
    resetN = 1'b0;
    last_owner = 0;
    tick();
    resetN = 1'b1;
    req = '0;
    check(gnt === '0, "rst_xfer_gnt", gnt, 0);
    check(bus_busy === 1'b0, "rst_xfer_busy", bus_busy, 0);
    check(owner === 2'd0, "rst_xfer_owner", owner, 0);
    rr = 0;
    tick();
    tick();
  endtask

  initial begin : monitor
    logic [N-1:0] prev, cur;
    int   len, gap;
    exp_t e;
    prev = '0;
    cur  = '0;
    len  = 0;
    gap  = 100;
    while (!done) begin
      @(negedge clk);
      if (mon_en) begin
        check($onehot0(gnt), "gnt_onehot", gnt, 0);
        check(bus_busy === (gnt != '0), "bus_busy", bus_busy, gnt != '0);
        if (gnt != '0) begin
          check(timeout_err === 1'b0, "terr_in_grant", timeout_err, 0);
          if (prev == '0) begin
            if (gap_exact) check(gap == 2, "turn_gap", gap, 2);
            else check(gap >= 2, "turn_gap_min", gap, 2);
            cur = gnt;
            len = 1;
            last_owner = idx_of(gnt);
            check(owner === 2'(last_owner), "owner", owner, last_owner);
          end else begin
            check(gnt === cur, "gnt_stable", gnt, cur);
            len++;
          end
        end else begin
          check(owner === 2'(last_owner), "owner_hold", owner, last_owner);
          if (prev != '0) begin
            if (sb.size() == 0) begin
              check(1'b0, "sb_underflow", 0, 1);
            end else begin
              e = sb.pop_front();
              check(idx_of(cur) == e.idx, "grant_idx", idx_of(cur), e.idx);
              check(len == e.len, "grant_len", len, e.len);
              check(timeout_err === e.te, "timeout_err", timeout_err, e.te);
            end
            gap = 1;
          end else begin
            check(timeout_err === 1'b0, "terr_spurious", timeout_err, 0);
            gap++;
          end
        end
        prev = gnt;
      end
    end
  end

  initial begin : driver
    logic [N-1:0] pat;
    int act, d;
    repeat (3) tick();
    resetN = 1'b1;
    check(gnt === '0, "rst_gnt", gnt, 0);
    check(owner === 2'd0, "rst_owner", owner, 0);
    check(bus_busy === 1'b0, "rst_busy", bus_busy, 0);
    check(timeout_err === 1'b0, "rst_terr", timeout_err, 0);
    mon_en = 1'b1;
    req = 4'b0001;
    tick();
    check(gnt === 4'b0001, "req_gnt_latency", gnt, 1);
    run_txn(4'b0001, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      run_txn(4'b1111, 0, int'($urandom_range(0, 7)), k == 2, 0, 1);
    run_txn(4'b0100, 2, 0, 0, 0, 1);
    run_txn(4'b1001, 0, 1, 0, 1, 1);
    run_txn(4'b1001, 0, 0, 0, 0, 1);
    run_txn(4'b0010, 1, 0, 0, 0, 1);
    run_txn(4'b1111, 0, 2, 0, 0, 1);
    reset_txn();
    run_txn(4'b1111, 0, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      pat = N'($urandom_range(1, 15));
      act = int'($urandom_range(0, 3));
      if (act == 3) act = 0;
      d = (act == 1) ? int'($urandom_range(0, 6))
                     : int'($urandom_range(0, 7));
      run_txn(pat, act, d, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1);
    end
    req = '0;
    repeat (4) tick();
    check(sb.size() == 0, "sb_drained", sb.size(), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
